// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
//   Shared definitions for the multi-channel FIFO controller.
//   - DEFAULT_DEPTH / DEFAULT_NUM_CH : default geometry
//   - clog2()                        : constant function for pointer and
//                                      counter widths
//   - ST_* localparams               : bit positions in the per-channel
//                                      packed status vector
package fifo_ctrl_pkg;

    localparam int DEFAULT_DEPTH  = 8;
    localparam int DEFAULT_NUM_CH = 4;

    // Status vector layout produced by fifo_ctrl_ch.
    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_AFULL  = 2;
    localparam int ST_AEMPTY = 3;
    localparam int ST_OVF    = 4;
    localparam int ST_UDF    = 5;
    localparam int ST_W      = 6;

    // Smallest r with 2**r >= v (returns 0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ctrl_ch.sv
// fifo_ctrl_ch
//   Control logic for one FIFO channel: access qualification, occupancy
//   counter, wrapping read/write pointers, status flags and error flags.
//   Build option: FIFO_CTRL_STICKY_ERR_EN makes overflow/underflow sticky
//   until err_clr; otherwise they are one-cycle pulses.
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   fifo_wr, fifo_rd                write / read requests
//   full_threshold, empty_threshold almost-full / almost-empty levels
//   err_clr                         clears sticky errors
//   wr_en, rd_en                    qualified accesses (combinational)
//   wr_ptr, rd_ptr                  memory addresses
//   count                           occupancy
//   status                          packed flags, layout ST_* in package
module fifo_ctrl_ch
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR   = clog2(DEPTH),
    parameter int CW    = clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_wr,
    input  logic            fifo_rd,
    input  logic [CW-1:0]   full_threshold,
    input  logic [CW-1:0]   empty_threshold,
    input  logic            err_clr,
    output logic            wr_en,
    output logic            rd_en,
    output logic [PTR-1:0]  wr_ptr,
    output logic [PTR-1:0]  rd_ptr,
    output logic [CW-1:0]   count,
    output logic [ST_W-1:0] status
);

    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [PTR-1:0] LAST_PTR = PTR'(DEPTH - 1);

    logic full;
    logic empty;
    logic ovf_evt;
    logic udf_evt;
    logic ovf_q;
    logic udf_q;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A full channel can still take a write when a read drains it in the
    // same cycle; an empty channel never grants a read.
    assign rd_en = fifo_rd & ~empty;
    assign wr_en = fifo_wr & (~full | fifo_rd);

    assign ovf_evt = fifo_wr & ~wr_en;
    assign udf_evt = fifo_rd & ~rd_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (wr_en & ~rd_en) begin
            count <= count + CW'(1);
        end else if (rd_en & ~wr_en) begin
            count <= count - CW'(1);
        end
    end

    // Pointers wrap explicitly at DEPTH-1 so any depth works.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR'(1);
            if (rd_en) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR'(1);
        end
    end

`ifdef FIFO_CTRL_STICKY_ERR_EN
    // New event takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_evt)      ovf_q <= 1'b1;
            else if (err_clr) ovf_q <= 1'b0;
            if (udf_evt)      udf_q <= 1'b1;
            else if (err_clr) udf_q <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_evt;
            udf_q <= udf_evt;
        end
    end
`endif

    always_comb begin
        status            = '0;
        status[ST_FULL]   = full;
        status[ST_EMPTY]  = empty;
        status[ST_AFULL]  = (count >= full_threshold);
        status[ST_AEMPTY] = (count <= empty_threshold);
        status[ST_OVF]    = ovf_q;
        status[ST_UDF]    = udf_q;
    end

endmodule

// File: rtl/fifo_ctrl_mc.sv
// fifo_ctrl_mc
//   Multi-channel FIFO controller: NUM_CH independent channels, each with
//   its own counter and pointers into a shared external memory.
//   Build option: FIFO_CTRL_STICKY_ERR_EN (sticky overflow/underflow).
// Handshake: fifo_wr/fifo_rd are per-channel requests, wr_en/rd_en are the
//   combinational grants in the same cycle; an access takes effect on the
//   rising edge where request and grant are both high. A refused request is
//   dropped (no hold required) and reported as overflow/underflow.
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   fifo_wr, fifo_rd [NUM_CH]       requests
//   full_threshold, empty_threshold shared almost-full/empty levels
//   err_clr                         clears sticky errors
//   wr_en, rd_en [NUM_CH]           qualified accesses
//   wr_ptr, rd_ptr [NUM_CH*PTR]     addresses, channel c at [c*PTR +: PTR]
//   count [NUM_CH*CW]               occupancy, channel c at [c*CW +: CW]
//   fifo_full, fifo_empty, almost_full, almost_empty [NUM_CH]
//   overflow, underflow [NUM_CH]    error flags
//   error                           OR of all error flags
module fifo_ctrl_mc
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int PTR    = clog2(DEPTH),
    parameter int CW     = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     fifo_wr,
    input  logic [NUM_CH-1:0]     fifo_rd,
    input  logic [CW-1:0]         full_threshold,
    input  logic [CW-1:0]         empty_threshold,
    input  logic                  err_clr,
    output logic [NUM_CH-1:0]     wr_en,
    output logic [NUM_CH-1:0]     rd_en,
    output logic [NUM_CH*PTR-1:0] wr_ptr,
    output logic [NUM_CH*PTR-1:0] rd_ptr,
    output logic [NUM_CH*CW-1:0]  count,
    output logic [NUM_CH-1:0]     fifo_full,
    output logic [NUM_CH-1:0]     fifo_empty,
    output logic [NUM_CH-1:0]     almost_full,
    output logic [NUM_CH-1:0]     almost_empty,
    output logic [NUM_CH-1:0]     overflow,
    output logic [NUM_CH-1:0]     underflow,
    output logic                  error
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ST_W-1:0] st;

        fifo_ctrl_ch #(
            .DEPTH (DEPTH),
            .PTR   (PTR),
            .CW    (CW)
        ) u_ch (
            .clk             (clk),
            .reset           (reset),
            .fifo_wr         (fifo_wr[c]),
            .fifo_rd         (fifo_rd[c]),
            .full_threshold  (full_threshold),
            .empty_threshold (empty_threshold),
            .err_clr         (err_clr),
            .wr_en           (wr_en[c]),
            .rd_en           (rd_en[c]),
            .wr_ptr          (wr_ptr[c*PTR +: PTR]),
            .rd_ptr          (rd_ptr[c*PTR +: PTR]),
            .count           (count[c*CW +: CW]),
            .status          (st)
        );

        assign fifo_full[c]    = st[ST_FULL];
        assign fifo_empty[c]   = st[ST_EMPTY];
        assign almost_full[c]  = st[ST_AFULL];
        assign almost_empty[c] = st[ST_AEMPTY];
        assign overflow[c]     = st[ST_OVF];
        assign underflow[c]    = st[ST_UDF];
    end

    assign error = |{overflow, underflow};

endmodule

// File: tb/tb_fifo_ctrl_mc.sv
module tb_fifo_ctrl_mc;

    localparam int NCH = 4;
    localparam int D   = 8;
    localparam int CWB = 4;
    localparam int PW  = 3;
    localparam int D5  = 5;
    localparam int CW5 = 3;
    localparam int PW5 = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (DEPTH 8, 4 channels) ----------------
    logic [NCH-1:0]     fifo_wr = '0, fifo_rd = '0;
    logic [CWB-1:0]     ft = 4'd6, et = 4'd2;
    logic               err_clr = 1'b0;
    logic [NCH-1:0]     wr_en, rd_en;
    logic [NCH*PW-1:0]  wr_ptr, rd_ptr;
    logic [NCH*CWB-1:0] count;
    logic [NCH-1:0]     fifo_full, fifo_empty, almost_full, almost_empty;
    logic [NCH-1:0]     overflow, underflow;
    logic               error;

    fifo_ctrl_mc #(.NUM_CH(NCH), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
        .full_threshold(ft), .empty_threshold(et), .err_clr(err_clr),
        .wr_en(wr_en), .rd_en(rd_en), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
        .count(count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .error(error)
    );

    // ---------------- DUT (DEPTH 5, 1 channel) ----------------
    logic [0:0]     d5_wr = '0, d5_rd = '0;
    logic [CW5-1:0] ft5 = 3'd4, et5 = 3'd1;
    logic [0:0]     wr_en5, rd_en5, full5, empty5, af5, ae5, ovf5, udf5;
    logic [PW5-1:0] wr_ptr5, rd_ptr5;
    logic [CW5-1:0] count5;
    logic           error5;

    fifo_ctrl_mc #(.NUM_CH(1), .DEPTH(D5)) dut5 (
        .clk(clk), .reset(reset), .fifo_wr(d5_wr), .fifo_rd(d5_rd),
        .full_threshold(ft5), .empty_threshold(et5), .err_clr(err_clr),
        .wr_en(wr_en5), .rd_en(rd_en5), .wr_ptr(wr_ptr5), .rd_ptr(rd_ptr5),
        .count(count5), .fifo_full(full5), .fifo_empty(empty5),
        .almost_full(af5), .almost_empty(ae5),
        .overflow(ovf5), .underflow(udf5), .error(error5)
    );

    // ---------------- reference model ----------------
    int tests = 0;
    int fails = 0;
    int m_cnt[NCH], m_wp[NCH], m_rp[NCH];
    bit m_ovf[NCH], m_udf[NCH];
    int m5_cnt, m5_wp, m5_rp;
    bit m5_ovf, m5_udf;
    logic [NCH-1:0] exp_wr_en, exp_rd_en, obs_wr_en, obs_rd_en;
    logic e5_wr, e5_rd, o5_wr, o5_rd;

    function automatic bit err_next(input bit cur, input bit evt, input bit clr);
`ifdef FIFO_CTRL_STICKY_ERR_EN
        return evt ? 1'b1 : (clr ? 1'b0 : cur);
`else
        return evt;
`endif
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_wp[c] = 0; m_rp[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
        end
        m5_cnt = 0; m5_wp = 0; m5_rp = 0; m5_ovf = 0; m5_udf = 0;
    endtask

    // ---------------- driver ----------------
    // One clock: drive requests, sample the combinational grants, advance
    // the model at the edge, return just after the edge.
    task automatic apply(input logic [NCH-1:0] wr, input logic [NCH-1:0] rd,
                         input logic w5, input logic r5, input logic clr);
        bit ov, ud;
        fifo_wr = wr; fifo_rd = rd; d5_wr = w5; d5_rd = r5; err_clr = clr;
        for (int c = 0; c < NCH; c++) begin
            exp_rd_en[c] = rd[c] && (m_cnt[c] > 0);
            exp_wr_en[c] = wr[c] && (m_cnt[c] < D || rd[c]);
        end
        e5_rd = r5 && (m5_cnt > 0);
        e5_wr = w5 && (m5_cnt < D5 || r5);
        #1;
        obs_wr_en = wr_en; obs_rd_en = rd_en; o5_wr = wr_en5[0]; o5_rd = rd_en5[0];
        @(posedge clk);
        for (int c = 0; c < NCH; c++) begin
            ov = wr[c] && !exp_wr_en[c];
            ud = rd[c] && !exp_rd_en[c];
            m_cnt[c] = m_cnt[c] + int'(exp_wr_en[c]) - int'(exp_rd_en[c]);
            m_wp[c]  = (m_wp[c] + int'(exp_wr_en[c])) % D;
            m_rp[c]  = (m_rp[c] + int'(exp_rd_en[c])) % D;
            m_ovf[c] = err_next(m_ovf[c], ov, clr);
            m_udf[c] = err_next(m_udf[c], ud, clr);
        end
        ov = w5 && !e5_wr;
        ud = r5 && !e5_rd;
        m5_cnt = m5_cnt + int'(e5_wr) - int'(e5_rd);
        m5_wp  = (m5_wp + int'(e5_wr)) % D5;
        m5_rp  = (m5_rp + int'(e5_rd)) % D5;
        m5_ovf = err_next(m5_ovf, ov, clr);
        m5_udf = err_next(m5_udf, ud, clr);
        #1;
    endtask

    task automatic do_reset();
        fifo_wr = '0; fifo_rd = '0; d5_wr = '0; d5_rd = '0; err_clr = 1'b0;
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        ft = 4'd0;
        #1;
        tests++;
        if (almost_full !== 4'hf) begin
            fails++; $display("FAIL reset_af_thr0: got %b exp 1111", almost_full);
        end
        ft = 4'd6;
        #1;
        tests++;
        if (count !== '0 || wr_ptr !== '0 || rd_ptr !== '0) begin
            fails++; $display("FAIL reset_state: count %h wp %h rp %h exp 0", count, wr_ptr, rd_ptr);
        end
        tests++;
        if (fifo_empty !== 4'hf || fifo_full !== 4'h0 || almost_empty !== 4'hf || almost_full !== 4'h0) begin
            fails++; $display("FAIL reset_flags: e %b f %b ae %b af %b exp 1111 0000 1111 0000",
                              fifo_empty, fifo_full, almost_empty, almost_full);
        end
        tests++;
        if (overflow !== '0 || underflow !== '0 || error !== 1'b0) begin
            fails++; $display("FAIL reset_err: ovf %b udf %b err %b exp 0", overflow, underflow, error);
        end
        tests++;
        if (count5 !== '0 || wr_ptr5 !== '0 || empty5 !== 1'b1 || error5 !== 1'b0) begin
            fails++; $display("FAIL reset_d5: count %0d wp %0d empty %b err %b exp 0 0 1 0",
                              count5, wr_ptr5, empty5, error5);
        end
        release_reset();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < D; i++) begin
            apply(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
            tests++;
            if (obs_wr_en[0] !== 1'b1) begin
                fails++; $display("FAIL fill_wr_en i%0d: got %b exp 1", i, obs_wr_en[0]);
            end
        end
        tests++;
        if (count[3:0] !== 4'd8 || fifo_full[0] !== 1'b1 || wr_ptr[2:0] !== 3'd0) begin
            fails++; $display("FAIL fill_full: count %0d full %b wp %0d exp 8 1 0",
                              count[3:0], fifo_full[0], wr_ptr[2:0]);
        end
        apply(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        tests++;
        if (obs_wr_en[0] !== 1'b0 || overflow[0] !== 1'b1 || count[3:0] !== 4'd8 || wr_ptr[2:0] !== 3'd0) begin
            fails++; $display("FAIL overflow: wr_en %b ovf %b count %0d wp %0d exp 0 1 8 0",
                              obs_wr_en[0], overflow[0], count[3:0], wr_ptr[2:0]);
        end
    endtask

    task automatic test_underflow();
        apply(4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0);
        tests++;
        if (obs_rd_en[1] !== 1'b0 || underflow[1] !== 1'b1 || rd_ptr[5:3] !== 3'd0 || count[7:4] !== 4'd0) begin
            fails++; $display("FAIL underflow: rd_en %b udf %b rp %0d count %0d exp 0 1 0 0",
                              obs_rd_en[1], underflow[1], rd_ptr[5:3], count[7:4]);
        end
        apply(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0);
        tests++;
        if (obs_wr_en[1] !== 1'b1 || obs_rd_en[1] !== 1'b0 || count[7:4] !== 4'd1 || underflow[1] !== 1'b1) begin
            fails++; $display("FAIL empty_rdwr: wr_en %b rd_en %b count %0d udf %b exp 1 0 1 1",
                              obs_wr_en[1], obs_rd_en[1], count[7:4], underflow[1]);
        end
        apply(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_full_rdwr();
        for (int i = 0; i < 3; i++) begin
            apply(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
            tests++;
            if (obs_wr_en[0] !== 1'b1 || obs_rd_en[0] !== 1'b1 || count[3:0] !== 4'd8 || error !== 1'b0) begin
                fails++; $display("FAIL full_rdwr i%0d: wr_en %b rd_en %b count %0d err %b exp 1 1 8 0",
                                  i, obs_wr_en[0], obs_rd_en[0], count[3:0], error);
            end
        end
        tests++;
        if (wr_ptr[2:0] !== 3'd3 || rd_ptr[2:0] !== 3'd3) begin
            fails++; $display("FAIL full_rdwr_ptr: wp %0d rp %0d exp 3 3", wr_ptr[2:0], rd_ptr[2:0]);
        end
    endtask

    task automatic test_depth5();
        for (int i = 0; i < 7; i++) begin
            apply(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
            tests++;
            if (o5_wr !== 1'b1 || wr_ptr5 !== 3'((i + 1) % D5) || count5 !== 3'd1) begin
                fails++; $display("FAIL d5_wr i%0d: wr_en %b wp %0d count %0d exp 1 %0d 1",
                                  i, o5_wr, wr_ptr5, count5, (i + 1) % D5);
            end
            apply(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
            tests++;
            if (o5_rd !== 1'b1 || rd_ptr5 !== 3'((i + 1) % D5) || count5 !== 3'd0) begin
                fails++; $display("FAIL d5_rd i%0d: rd_en %b rp %0d count %0d exp 1 %0d 0",
                                  i, o5_rd, rd_ptr5, count5, (i + 1) % D5);
            end
        end
        for (int i = 0; i < D5 + 1; i++) apply(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        tests++;
        if (count5 !== 3'd5 || full5 !== 1'b1 || ovf5 !== 1'b1 || o5_wr !== 1'b0) begin
            fails++; $display("FAIL d5_full: count %0d full %b ovf %b wr_en %b exp 5 1 1 0",
                              count5, full5, ovf5, o5_wr);
        end
        apply(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_thresholds();
        ft = 4'd6; et = 4'd2;
        for (int k = 0; k <= D; k++) begin
            tests++;
            if (almost_full[2] !== (k >= 6) || almost_empty[2] !== (k <= 2) || count[11:8] !== 4'(k)) begin
                fails++; $display("FAIL thresh k%0d: af %b ae %b count %0d exp %b %b %0d",
                                  k, almost_full[2], almost_empty[2], count[11:8], k >= 6, k <= 2, k);
            end
            if (k < D) apply(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_errors();
        bit exp_hold;
        apply(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        tests++;
        if (overflow[2] !== 1'b1 || error !== 1'b1) begin
            fails++; $display("FAIL err_set: ovf %b err %b exp 1 1", overflow[2], error);
        end
`ifdef FIFO_CTRL_STICKY_ERR_EN
        exp_hold = 1'b1;
`else
        exp_hold = 1'b0;
`endif
        for (int i = 0; i < 5; i++) begin
            apply(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
            tests++;
            if (overflow[2] !== exp_hold || error !== exp_hold) begin
                fails++; $display("FAIL err_hold i%0d: ovf %b err %b exp %b", i, overflow[2], error, exp_hold);
            end
        end
        apply(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        tests++;
        if (overflow[2] !== 1'b0 || error !== 1'b0) begin
            fails++; $display("FAIL err_clr: ovf %b err %b exp 0 0", overflow[2], error);
        end
    endtask

    task automatic test_random();
        int pw, pr;
        logic [NCH-1:0] wr, rd;
        logic w5, r5, clr;
        bit any_err;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 100 == 0) begin
                ft = 4'($urandom_range(0, D));
                et = 4'($urandom_range(0, D));
                ft5 = 3'($urandom_range(0, D5));
                et5 = 3'($urandom_range(0, D5));
            end
            pw = (cyc < 200) ? 70 : (cyc < 400) ? 30 : 50;
            pr = 100 - pw;
            for (int c = 0; c < NCH; c++) begin
                wr[c] = ($urandom_range(0, 99) < pw);
                rd[c] = ($urandom_range(0, 99) < pr);
            end
            w5 = ($urandom_range(0, 99) < pw);
            r5 = ($urandom_range(0, 99) < pr);
            clr = ($urandom_range(0, 7) == 0);
            apply(wr, rd, w5, r5, clr);
            tests++;
            if (obs_wr_en !== exp_wr_en || obs_rd_en !== exp_rd_en) begin
                fails++; $display("FAIL rnd_en cyc%0d: wr_en %b rd_en %b exp %b %b",
                                  cyc, obs_wr_en, obs_rd_en, exp_wr_en, exp_rd_en);
            end
            any_err = 0;
            for (int c = 0; c < NCH; c++) begin
                any_err |= m_ovf[c] | m_udf[c];
                tests++;
                if (count[c*CWB +: CWB] !== 4'(m_cnt[c]) || wr_ptr[c*PW +: PW] !== 3'(m_wp[c]) ||
                    rd_ptr[c*PW +: PW] !== 3'(m_rp[c])) begin
                    fails++; $display("FAIL rnd_state cyc%0d ch%0d: count %0d wp %0d rp %0d exp %0d %0d %0d",
                                      cyc, c, count[c*CWB +: CWB], wr_ptr[c*PW +: PW], rd_ptr[c*PW +: PW],
                                      m_cnt[c], m_wp[c], m_rp[c]);
                end
                tests++;
                if (fifo_full[c] !== (m_cnt[c] == D) || fifo_empty[c] !== (m_cnt[c] == 0) ||
                    almost_full[c] !== (m_cnt[c] >= int'(ft)) || almost_empty[c] !== (m_cnt[c] <= int'(et))) begin
                    fails++; $display("FAIL rnd_flags cyc%0d ch%0d: f %b e %b af %b ae %b cnt %0d ft %0d et %0d",
                                      cyc, c, fifo_full[c], fifo_empty[c], almost_full[c], almost_empty[c],
                                      m_cnt[c], ft, et);
                end
                tests++;
                if (overflow[c] !== m_ovf[c] || underflow[c] !== m_udf[c]) begin
                    fails++; $display("FAIL rnd_err cyc%0d ch%0d: ovf %b udf %b exp %b %b",
                                      cyc, c, overflow[c], underflow[c], m_ovf[c], m_udf[c]);
                end
            end
            tests++;
            if (error !== any_err) begin
                fails++; $display("FAIL rnd_error cyc%0d: got %b exp %b", cyc, error, any_err);
            end
            tests++;
            if (o5_wr !== e5_wr || o5_rd !== e5_rd || count5 !== 3'(m5_cnt) || wr_ptr5 !== 3'(m5_wp) ||
                rd_ptr5 !== 3'(m5_rp) || full5 !== (m5_cnt == D5) || empty5 !== (m5_cnt == 0) ||
                af5 !== (m5_cnt >= int'(ft5)) || ae5 !== (m5_cnt <= int'(et5)) ||
                ovf5 !== m5_ovf || udf5 !== m5_udf || error5 !== (m5_ovf | m5_udf)) begin
                fails++; $display("FAIL rnd_d5 cyc%0d: en %b%b cnt %0d wp %0d rp %0d ovf %b udf %b exp en %b%b cnt %0d wp %0d rp %0d ovf %b udf %b",
                                  cyc, o5_wr, o5_rd, count5, wr_ptr5, rd_ptr5, ovf5, udf5,
                                  e5_wr, e5_rd, m5_cnt, m5_wp, m5_rp, m5_ovf, m5_udf);
            end
        end
    endtask

    task automatic test_reset_mid();
        ft = 4'd6; et = 4'd2;
        apply(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) apply(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if (count !== '0 || wr_ptr !== '0 || rd_ptr !== '0 || count5 !== '0 || wr_ptr5 !== '0 || rd_ptr5 !== '0) begin
            fails++; $display("FAIL mid_reset_state: count %h wp %h rp %h count5 %0d", count, wr_ptr, rd_ptr, count5);
        end
        tests++;
        if (fifo_empty !== 4'hf || fifo_full !== 4'h0 || almost_empty !== 4'hf || almost_full !== 4'h0 ||
            overflow !== '0 || underflow !== '0 || error !== 1'b0) begin
            fails++; $display("FAIL mid_reset_flags: e %b f %b ae %b af %b ovf %b udf %b err %b",
                              fifo_empty, fifo_full, almost_empty, almost_full, overflow, underflow, error);
        end
        fifo_wr = '0; fifo_rd = '0; d5_wr = '0; d5_rd = '0; err_clr = 1'b0;
        model_clear();
        release_reset();
        apply(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        tests++;
        if (obs_wr_en[0] !== 1'b1 || count[3:0] !== 4'd1) begin
            fails++; $display("FAIL post_reset_wr: wr_en %b count %0d exp 1 1", obs_wr_en[0], count[3:0]);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fill_overflow();
        test_underflow();
        test_full_rdwr();
        test_depth5();
        test_thresholds();
        test_errors();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
